// File: rtl/reflet_ram8_word_master.sv
// reflet_ram8_word_master
// Bridges a wordSize-bit requester onto an 8-bit synchronous RAM port.
// Each request is split into byte accesses at consecutive addresses, and
// read bytes are reassembled into rsp_data. The RAM has a registered read
// with one cycle of latency.
//
// Optional build macro: REFLET_RAM8_MASTER_BIG_ENDIAN_EN
//   When it is defined, transfer byte i maps to word byte N-1-i for both
//   write data and read assembly. Byte-mode access always uses bits 7:0.
//   When it is undefined, byte order is little-endian.
//
// Handshake: req is sampled only in IDLE. busy is high from the cycle after
// the accept edge through the DONE cycle. rsp_done pulses for one cycle in
// DONE. A requester must keep req held until busy drops before it can
// present another request.
module reflet_ram8_word_master #(
  parameter int wordSize = 16,
  parameter int addrSize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [addrSize-1:0] req_addr,
  input  logic                req_write,
  input  logic                req_byte,
  input  logic [wordSize-1:0] req_data,
  output logic [wordSize-1:0] rsp_data,
  output logic                rsp_done,
  output logic                busy,
  output logic                ram_enable,
  output logic [addrSize-1:0] ram_addr,
  output logic [7:0]          ram_wdata,
  output logic                ram_write_en,
  input  logic [7:0]          ram_rdata
);

  localparam int NB = wordSize / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [addrSize-1:0] addr_q, addr_d;
  logic                write_q, write_d;
  logic                byte_q, byte_d;
  logic [wordSize-1:0] data_q, data_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [wordSize-1:0] buf_q, buf_d;
  logic [wordSize-1:0] rsp_q, rsp_d;

  // Byte-lane helpers: last transfer index, lane for write/capture, and
  // the buffer with the byte arriving this cycle merged in.
  logic [IW-1:0]       last_idx;
  logic [IW-1:0]       cap_idx;
  logic [IW-1:0]       pos_w;
  logic [IW-1:0]       pos_r;
  logic [7:0]          wbyte;
  logic [wordSize-1:0] cap_buf;

  // State and latched-request registers; reset aborts any transfer at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      rsp_q   <= rsp_d;
    end
  end

  // Lane selection. The read byte that arrives now belongs to the previous
  // index in XFER, or to the held last index in TAIL.
  always_comb begin
    last_idx = byte_q ? '0 : IW'(NB - 1);
    cap_idx  = (state_q == S_TAIL) ? idx_q : (idx_q - IW'(1));
`ifdef REFLET_RAM8_MASTER_BIG_ENDIAN_EN
    pos_w    = last_idx - idx_q;
    pos_r    = last_idx - cap_idx;
`else
    pos_w    = idx_q;
    pos_r    = cap_idx;
`endif
    wbyte   = '0;
    cap_buf = buf_q;
    for (int b = 0; b < NB; b++) begin
      if (int'(pos_w) == b) wbyte = data_q[b*8 +: 8];
      if (int'(pos_r) == b) cap_buf[b*8 +: 8] = ram_rdata;
    end
  end

  // Next-state and output decode. Outputs depend only on registered state,
  // so every output is 0 while reset is held low.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    write_d      = write_q;
    byte_d       = byte_q;
    data_d       = data_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    rsp_d        = rsp_q;
    busy         = 1'b0;
    rsp_done     = 1'b0;
    ram_enable   = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_write_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = req_addr;
          write_d = req_write;
          byte_d  = req_byte;
          data_d  = req_data;
          idx_d   = '0;
          buf_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        busy         = 1'b1;
        ram_enable   = 1'b1;
        ram_addr     = addr_q + addrSize'(idx_q);
        ram_write_en = write_q;
        ram_wdata    = write_q ? wbyte : 8'h00;
        if (!write_q && (idx_q != '0)) buf_d = cap_buf;
        if (idx_q == last_idx) begin
          state_d = write_q ? S_DONE : S_TAIL;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_TAIL: begin
        busy       = 1'b1;
        ram_enable = 1'b1;
        ram_addr   = addr_q + addrSize'(idx_q);
        buf_d      = cap_buf;
        rsp_d      = cap_buf;
        state_d    = S_DONE;
      end
      S_DONE: begin
        busy     = 1'b1;
        rsp_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_data = rsp_q;

endmodule

// File: tb/tb_reflet_ram8_word_master.sv
// Directed testbench for reflet_ram8_word_master (wordSize=16, addrSize=16).
// Contains a behavioural 8-bit synchronous RAM, a driver task that queues
// the expected bus accesses and responses, and a negedge monitor that pops
// and compares them.
module tb_reflet_ram8_word_master;

  localparam int W  = 16;
  localparam int AW = 16;
`ifdef REFLET_RAM8_MASTER_BIG_ENDIAN_EN
  localparam bit BE = 1'b1;
  localparam logic [W-1:0] EXP_BRD_11 = 16'h00EF;
  localparam logic [W-1:0] EXP_RD_5A  = 16'h5AEF;
  localparam logic [W-1:0] EXP_BRD_00 = 16'h0034;
`else
  localparam bit BE = 1'b0;
  localparam logic [W-1:0] EXP_BRD_11 = 16'h00BE;
  localparam logic [W-1:0] EXP_RD_5A  = 16'hBE5A;
  localparam logic [W-1:0] EXP_BRD_00 = 16'h0012;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [7:0]    wdata;
  } bus_t;

  logic          clk;
  logic          reset;
  logic          req;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic          req_byte;
  logic [W-1:0]  req_data;
  logic [W-1:0]  rsp_data;
  logic          rsp_done;
  logic          busy;
  logic          ram_enable;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wdata;
  logic          ram_write_en;
  logic [7:0]    ram_rdata;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  bus_t         bus_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  bit busy_prev = 1'b0;

  logic [7:0] mem [0:65535];

  reflet_ram8_word_master #(.wordSize(W), .addrSize(AW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_write(req_write), .req_byte(req_byte), .req_data(req_data),
    .rsp_data(rsp_data), .rsp_done(rsp_done), .busy(busy),
    .ram_enable(ram_enable), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_write_en(ram_write_en), .ram_rdata(ram_rdata)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: registered read, read-before-write
  always @(posedge clk) begin
    if (ram_enable) begin
      ram_rdata <= mem[ram_addr];
      if (ram_write_en) mem[ram_addr] = ram_wdata;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  // Monitor: bus accesses and completions, compared against queued model
  always @(negedge clk) begin
    if (!reset) begin
      busy_prev = 1'b0;
    end else begin
      check("we_without_enable", {63'd0, ram_write_en & ~ram_enable}, 64'd0);
      if (busy && !busy_prev) start_cyc = cyc;
      if (ram_enable) begin
        if (bus_q.size() == 0) begin
          check("unexpected_ram_access", 64'd1, 64'd0);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          check("ram_addr", {48'd0, ram_addr}, {48'd0, e.addr});
          check("ram_write_en", {63'd0, ram_write_en}, {63'd0, e.we});
          if (e.we) check("ram_wdata", {56'd0, ram_wdata}, {56'd0, e.wdata});
        end
      end
      if (rsp_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp_done", 64'd1, 64'd0);
        end else begin
          logic [W-1:0] ed;
          int el;
          ed = exp_q.pop_front();
          el = lat_q.pop_front();
          check("rsp_data", {48'd0, rsp_data}, {48'd0, ed});
          check("latency", 64'(cyc - start_cyc + 1), 64'(el));
          check("busy_at_done", {63'd0, busy}, 64'd1);
        end
      end
      busy_prev = busy;
      cyc++;
    end
  end

  // Driver: issue one request, queue expectations, wait for completion
  task automatic do_req(input logic wr, input logic byt, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input logic [W-1:0] exp_rsp);
    int n;
    bit seen;
    n = byt ? 1 : W / 8;
    for (int i = 0; i < n; i++) begin
      bus_t e;
      int pos;
      pos = byt ? 0 : (BE ? (n - 1 - i) : i);
      e.addr  = a + AW'(i);
      e.we    = wr;
      e.wdata = d[pos*8 +: 8];
      bus_q.push_back(e);
    end
    if (!wr) begin
      bus_t t;
      t.addr  = a + AW'(n - 1);
      t.we    = 1'b0;
      t.wdata = 8'h00;
      bus_q.push_back(t);
    end
    exp_q.push_back(exp_rsp);
    lat_q.push_back(wr ? n + 1 : n + 2);
    @(negedge clk);
    req = 1'b1; req_write = wr; req_byte = byt; req_addr = a; req_data = d;
    @(posedge clk);
    #1;
    req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rsp_data"}, {48'd0, rsp_data}, 64'd0);
    check({tag, "_rsp_done"}, {63'd0, rsp_done}, 64'd0);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_ram_enable"}, {63'd0, ram_enable}, 64'd0);
    check({tag, "_ram_addr"}, {48'd0, ram_addr}, 64'd0);
    check({tag, "_ram_wdata"}, {56'd0, ram_wdata}, 64'd0);
    check({tag, "_ram_write_en"}, {63'd0, ram_write_en}, 64'd0);
  endtask

  // Stimulus
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset = 1'b0; req = 1'b0; req_addr = '0; req_write = 1'b0;
    req_byte = 1'b0; req_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    #2 reset = 1'b1;

    do_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000);     // word write
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);     // word read
    do_req(1'b0, 1'b1, 16'h0011, 16'h0000, EXP_BRD_11);   // byte read
    do_req(1'b1, 1'b1, 16'h0010, 16'h775A, EXP_BRD_11);   // byte write
    do_req(1'b0, 1'b0, 16'h0010, 16'h0000, EXP_RD_5A);    // word read
    do_req(1'b1, 1'b0, 16'hFFFF, 16'h1234, EXP_RD_5A);    // wrapping write
    do_req(1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h1234);     // wrapping read
    do_req(1'b0, 1'b1, 16'h0000, 16'h0000, EXP_BRD_00);   // wrapped byte

    // Abort a write during its first cycle, before the edge that would store it
    @(negedge clk);
    req = 1'b1; req_write = 1'b1; req_byte = 1'b0;
    req_addr = 16'h0020; req_data = 16'hAAAA;
    @(posedge clk);
    #1 req = 1'b0;
    #2 reset = 1'b0;
    #1 check_idle_outputs("abort");
    repeat (3) @(negedge clk);
    check_idle_outputs("abort_hold");
    #2 reset = 1'b1;
    do_req(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000);     // nothing stored

    repeat (3) @(negedge clk);
    check("leftover_rsp", 64'(exp_q.size()), 64'd0);
    check("leftover_bus", 64'(bus_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reflet_ram8_word_master.md
Name: reflet_ram8_word_master

Overview:
- Bus initiator that drives an 8-bit synchronous RAM port (one address, registered read, 1-cycle read latency) on behalf of a wider requester (CPU or peripheral).
- Splits each word or byte request into sequential byte accesses and reassembles read data.
- Sits between the CPU data port and the 8-bit RAM blocks of the microcontroller.

Parameters:
- wordSize, 16, requester data width in bits; multiple of 8, range 8..64.
- addrSize, 16, address width on both sides.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- req  input  1  request strobe; sampled only in IDLE
- req_addr  input  addrSize  byte address of lowest byte
- req_write  input  1  1 = write, 0 = read
- req_byte  input  1  1 = single-byte access, 0 = full word
- req_data  input  wordSize  write data
- rsp_data  output  wordSize  read data
- rsp_done  output  1  one-cycle completion pulse
- busy  output  1  high from accept until the done cycle inclusive
- ram_enable  output  1  RAM enable
- ram_addr  output  addrSize  RAM address
- ram_wdata  output  8  byte written to RAM
- ram_write_en  output  1  RAM write strobe
- ram_rdata  input  8  RAM read data; valid the cycle after the address is presented, only while enable stays high

Behaviour:
- Reset: clk and reset as above; reset is asynchronous and active-low.
  - All outputs are 0 while reset is low; state = IDLE; latched request cleared.
  - Reset asserted mid-operation aborts immediately. No further RAM writes. Bytes already written stay written. No rsp_done.
- N = 1 if req_byte, else wordSize/8. Byte i goes to address (req_addr + i) mod 2^addrSize; wrap is silent.
- FSM states: IDLE, XFER, TAIL, DONE.
  - IDLE: if req, latch addr/write/byte/data, set busy, go XFER; byte index i = 0.
  - XFER, cycle per byte i: ram_enable = 1, ram_addr = base + i, ram_write_en = write.
    - ram_wdata = byte i of data (byte 0 = bits 7:0, little-endian).
    - Read: ram_rdata captured the following cycle into byte i-1 of rsp_data.
    - After i = N-1: write goes DONE; read goes TAIL.
  - TAIL (read only): ram_enable = 1, ram_addr held at base + N-1, ram_write_en = 0; capture last byte; go DONE.
  - DONE: rsp_done = 1 for exactly one cycle; busy = 1; RAM outputs 0; next state IDLE. A req present in DONE is ignored; the requester must hold it until IDLE.
- Latency from the accept edge to rsp_done:
  - Write: N+1 cycles.
  - Read: N+2 cycles.
- rsp_data holds its value from DONE until the next read completes.
  - Byte-mode read zero-extends: bits above 7 = 0.
  - Writes do not modify rsp_data.
- ram_write_en is never high while ram_enable is low. ram_enable is 0 in IDLE and DONE.
- Bytes outside the RAM's implemented range read as 0 (RAM behaviour); the master does no range checking.

Optional Feature:
- Macro: REFLET_RAM8_MASTER_BIG_ENDIAN_EN.
- Defined: byte i of the transfer maps to bits of word byte N-1-i, for both writes and read assembly. Byte mode is unaffected (always bits 7:0).
- Undefined: little-endian as above.

Test Plan:
- wordSize=16, write req_addr=0x0010, req_data=0xBEEF:
  - Cycle 1: ram_addr=0x0010, ram_wdata=0xEF, ram_write_en=1.
  - Cycle 2: ram_addr=0x0011, ram_wdata=0xBE, ram_write_en=1.
  - Cycle 3: rsp_done=1. busy high for all 3 cycles.
- Read back 0x0010: ram_enable high for 3 cycles (addr 0x10, 0x11, 0x11). rsp_done on cycle 4 with rsp_data=0xBEEF.
- Byte read at 0x0011 after above: rsp_data=0x00BE, done on cycle 3. Byte write 0x5A to 0x0010, then word read of 0x0010 -> 0xBE5A.
- Wrap: addrSize=16, word write 0x1234 at 0xFFFF -> 0x34 to 0xFFFF, 0x12 to 0x0000; word read at 0xFFFF returns 0x1234.
- Reset pulled low in cycle 1 of a write to 0x0020 with data 0xAAAA:
  - All outputs 0 immediately; no rsp_done.
  - After release, a word read of 0x0020 returns low byte 0xAA only if cycle 1's clock edge had already occurred, else 0x0000; high byte = 0x00.
- With REFLET_RAM8_MASTER_BIG_ENDIAN_EN: write 0xBEEF to 0x0010 -> RAM[0x10]=0xBE, RAM[0x11]=0xEF; read back returns 0xBEEF.
